// File: rtl/udp_tx_csum.sv
// udp_tx_csum: computes the UDP checksum and streams header, FIFO payload and zero padding
module udp_tx_csum #(
  parameter int DATA_W = 16,
  parameter int CSUM_EN = 1,
  parameter int MIN_PAYLOAD = 18,
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       source_ip_addr,
  input  logic [31:0]       destination_ip_addr,
  input  logic [15:0]       udp_send_source_port,
  input  logic [15:0]       udp_send_destination_port,
  input  logic [15:0]       udp_send_data_length,
  input  logic [15:0]       payload_csum,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              udp_tx_req,
  input  logic              udp_data_req,
  output logic              udp_tx_ready,
  output logic              udp_tx_valid,
  output logic [7:0]        udp_tx_data,
  output logic              udp_tx_done,
  output logic              udp_tx_timeout
);
  localparam int B = DATA_W / 8;
  typedef enum logic [3:0] {IDLE = 4'b0001, CSUM = 4'b0010, SEND_WAIT = 4'b0100, UDP_SEND = 4'b1000} state_t;
  state_t state, nxt;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] sport, dport, len, pcsum, udp_len, total, csum, n, p, off, term, cres, f2;
  logic [15:0] t [10];
  logic [7:0] hdr [8];
  logic [19:0] acc, sum;
  logic [16:0] f1;
  logic [3:0] ci;
  logic [TIMEOUT_W-1:0] tmo;
  logic [DATA_W-1:0] word;
  logic [7:0] tx_byte;
  logic rd_q, last_q, rd_go, last, pay;
  always_comb begin
    t = '{src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0], 16'h0011, udp_len, sport, dport, udp_len, pcsum};
    term = t[ci];
    sum = acc + {4'h0, term};
    f1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    f2 = f1[15:0] + {15'h0, f1[16]};
    cres = CSUM_EN == 0 ? 16'h0000 : f2 == 16'hFFFF ? 16'hFFFF : ~f2;
    hdr = '{sport[15:8], sport[7:0], dport[15:8], dport[7:0], udp_len[15:8], udp_len[7:0], csum[15:8], csum[7:0]};
    p = n - 16'd5;
    off = n - 16'd8;
    pay = n >= 16'd8 && off < len;
    rd_go = n >= 16'd5 && p < len && (p & 16'(B - 1)) == 16'h0;
    last = n == total - 16'd1;
    tx_byte = n < 16'd8 ? hdr[n[2:0]] : pay ? word[DATA_W-1 -: 8] : 8'h00;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = udp_tx_req ? CSUM : IDLE;
      CSUM:      nxt = ci == 4'd9 ? SEND_WAIT : CSUM;
      SEND_WAIT: nxt = udp_data_req ? UDP_SEND : &tmo ? IDLE : SEND_WAIT;
      UDP_SEND:  nxt = last ? IDLE : UDP_SEND;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ip <= '0;
      dst_ip <= '0;
      sport <= '0;
      dport <= '0;
      len <= '0;
      pcsum <= '0;
      udp_len <= '0;
      total <= '0;
      csum <= '0;
      acc <= '0;
      ci <= '0;
      tmo <= '0;
      n <= '0;
      word <= '0;
      rd_q <= 1'b0;
      last_q <= 1'b0;
      fifo_rd_en <= 1'b0;
      udp_tx_ready <= 1'b0;
      udp_tx_valid <= 1'b0;
      udp_tx_data <= 8'h00;
      udp_tx_done <= 1'b0;
      udp_tx_timeout <= 1'b0;
    end else begin
      if (state == IDLE && udp_tx_req) begin
        src_ip <= source_ip_addr;
        dst_ip <= destination_ip_addr;
        sport <= udp_send_source_port;
        dport <= udp_send_destination_port;
        len <= udp_send_data_length;
        pcsum <= payload_csum;
        udp_len <= udp_send_data_length + 16'd8;
        total <= (udp_send_data_length > 16'(MIN_PAYLOAD) ? udp_send_data_length : 16'(MIN_PAYLOAD)) + 16'd8;
      end
      if (state == CSUM && ci == 4'd9) csum <= cres;
      acc <= state == CSUM ? sum : '0;
      ci <= state == CSUM ? ci + 4'd1 : 4'd0;
      tmo <= state == SEND_WAIT ? tmo + TIMEOUT_W'(1) : '0;
      n <= state == UDP_SEND ? n + 16'd1 : 16'd0;
      udp_tx_ready <= state == SEND_WAIT;
      udp_tx_timeout <= state == SEND_WAIT && !udp_data_req && &tmo;
      fifo_rd_en <= state == UDP_SEND && rd_go;
      rd_q <= fifo_rd_en;
      word <= rd_q ? fifo_data : state == UDP_SEND && pay ? word << 8 : word;
      udp_tx_valid <= state == UDP_SEND;
      udp_tx_data <= state == UDP_SEND ? tx_byte : 8'h00;
      last_q <= state == UDP_SEND && last;
      udp_tx_done <= last_q;
    end
  end
endmodule

// File: tb/tb_udp_tx_csum.sv
// tb_udp_tx_csum: scoreboard bench over four udp_tx_csum configurations
module tb_udp_tx_csum;
  logic clk = 0, rst = 1, data_req = 0;
  logic [31:0] sip = 0, dip = 0;
  logic [15:0] sp = 0, dp = 0, len = 0, pcs = 0;
  logic req [4];
  logic rd_en [4], ready [4], valid [4], done [4], tmo_o [4];
  logic [7:0] data [4];
  logic [7:0] pl [128];
  logic [7:0] exp_q [$];
  int ncmp = 0, nfail = 0, cur = 0, reads = 0, nbytes = 0, tot = 0;
  logic done_due = 0, done_seen = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int DW = g == 1 ? 32 : g == 2 ? 8 : 16;
    logic [DW-1:0] fd;
    int rp;
    udp_tx_csum #(.DATA_W(DW), .CSUM_EN(g == 3 ? 0 : 1), .MIN_PAYLOAD(18), .TIMEOUT_W(4)) u (
      .clk(clk), .rst(rst), .source_ip_addr(sip), .destination_ip_addr(dip),
      .udp_send_source_port(sp), .udp_send_destination_port(dp), .udp_send_data_length(len),
      .payload_csum(pcs), .fifo_data(fd), .fifo_rd_en(rd_en[g]), .udp_tx_req(req[g]),
      .udp_data_req(data_req), .udp_tx_ready(ready[g]), .udp_tx_valid(valid[g]),
      .udp_tx_data(data[g]), .udp_tx_done(done[g]), .udp_tx_timeout(tmo_o[g]));
    always @(posedge clk)
      if (req[g]) rp <= 0;
      else if (rd_en[g]) begin
        for (int b = 0; b < DW / 8; b++) fd[DW-1-8*b -: 8] <= pl[rp+b];
        rp <= rp + DW / 8;
      end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  function automatic logic [15:0] fold(input logic [31:0] s);
    for (int i = 0; i < 3; i++) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en[cur]) reads++;
      if (valid[cur]) begin
        chk("byte_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk($sformatf("byte%0d", nbytes), data[cur], exp_q.pop_front());
          nbytes++;
        end
      end else chk("idle_data", data[cur], 0);
      if (done[cur] || done_due) chk("done_timing", done[cur], done_due);
      if (done[cur]) done_seen = 1;
      done_due = valid[cur] && exp_q.size() == 0;
    end
  end
  task automatic start_frame(input int g, input int l, input logic [15:0] s_p, input logic [15:0] d_p,
                             input logic [31:0] s_ip, input logic [31:0] d_ip, input int pat);
    logic [31:0] s, ps;
    logic [15:0] ul, c;
    int t;
    cur = g;
    for (int k = 0; k < 128; k++) pl[k] = k >= l ? 8'hEE : pat == 0 ? 8'(k) : pat == 1 ? 8'($urandom) : 8'(k * 37 + 3);
    ps = 0;
    for (int k = 0; k < l; k += 2) ps += {16'h0, pl[k], k + 1 < l ? pl[k+1] : 8'h00};
    ul = 16'(l + 8);
    tot = (l > 18 ? l : 18) + 8;
    s = ps + {16'h0, s_ip[31:16]} + {16'h0, s_ip[15:0]} + {16'h0, d_ip[31:16]} + {16'h0, d_ip[15:0]}
        + 32'h11 + {16'h0, ul} + {16'h0, s_p} + {16'h0, d_p} + {16'h0, ul};
    c = ~fold(s);
    if (c == 16'h0) c = 16'hFFFF;
    if (g == 3) c = 16'h0;
    exp_q.delete();
    exp_q.push_back(s_p[15:8]); exp_q.push_back(s_p[7:0]);
    exp_q.push_back(d_p[15:8]); exp_q.push_back(d_p[7:0]);
    exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
    exp_q.push_back(c[15:8]); exp_q.push_back(c[7:0]);
    for (int k = 0; k < tot - 8; k++) exp_q.push_back(k < l ? pl[k] : 8'h00);
    sip = s_ip; dip = d_ip; sp = s_p; dp = d_p; len = 16'(l); pcs = fold(ps);
    reads = 0; nbytes = 0; done_seen = 0; done_due = 0;
    req[g] = 1;
    tick;
    req[g] = 0;
    t = 0;
    while (!ready[g] && t < 40) begin tick; t++; end
    chk("ready", ready[g], 1);
    tick;
    data_req = 1;
    tick;
    data_req = 0;
  endtask
  task automatic finish_frame(input int g, input int l);
    int t, bw;
    bw = g == 1 ? 4 : g == 2 ? 1 : 2;
    t = 0;
    while (!done_seen && t < 200) begin tick; t++; end
    chk("done_seen", done_seen, 1);
    chk("byte_count", nbytes, tot);
    chk("reads", reads, (l + bw - 1) / bw);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    tick;
  endtask
  task automatic run_frame(input int g, input int l, input logic [15:0] s_p, input logic [15:0] d_p,
                           input logic [31:0] s_ip, input logic [31:0] d_ip, input int pat);
    start_frame(g, l, s_p, d_p, s_ip, d_ip, pat);
    finish_frame(g, l);
  endtask
  initial begin
    int nr, nt, t;
    for (int i = 0; i < 4; i++) req[i] = 0;
    repeat (3) tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid%0d", i), valid[i], 0);
      chk($sformatf("rst_data%0d", i), data[i], 0);
      chk($sformatf("rst_rd%0d", i), rd_en[i], 0);
      chk($sformatf("rst_ready%0d", i), ready[i], 0);
      chk($sformatf("rst_done%0d", i), done[i], 0);
      chk($sformatf("rst_tmo%0d", i), tmo_o[i], 0);
    end
    rst = 0;
    tick;
    run_frame(0, 32, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 0);
    run_frame(0, 5, 16'h1234, 16'h5678, 32'h0A000001, 32'h0A0000FE, 1);
    run_frame(1, 7, 16'hABCD, 16'h0035, 32'hAC100001, 32'hAC100002, 2);
    run_frame(2, 7, 16'hABCD, 16'h0035, 32'hAC100001, 32'hAC100002, 2);
    run_frame(0, 0, 16'h0000, 16'hFFDE, 32'h0, 32'h0, 0);
    run_frame(3, 0, 16'h0000, 16'hFFDE, 32'h0, 32'h0, 0);
    run_frame(3, 20, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 1);
    cur = 0; reads = 0; nr = 0; nt = 0;
    req[0] = 1;
    tick;
    req[0] = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      nr += int'(ready[0]);
      nt += int'(tmo_o[0]);
    end
    chk("ready_cycles", nr, 16);
    chk("timeout_pulses", nt, 1);
    chk("timeout_reads", reads, 0);
    chk("timeout_ready_low", ready[0], 0);
    start_frame(0, 32, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 0);
    t = 0;
    while (nbytes < 13 && t < 100) begin tick; t++; end
    chk("reached_byte12", 32'(nbytes >= 13), 1);
    rst = 1;
    tick;
    chk("abort_valid", valid[0], 0);
    chk("abort_data", data[0], 0);
    chk("abort_rd", rd_en[0], 0);
    chk("abort_ready", ready[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_tmo", tmo_o[0], 0);
    rst = 0;
    exp_q.delete();
    reads = 0;
    repeat (20) tick;
    chk("reads_after_rst", reads, 0);
    run_frame(0, 32, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
